// File: rtl/pipe_return_buffer.sv
// Return buffer for a fixed-latency, stall-free pipeline. Launches are granted
// only when a free slot can be reserved, so every returning result has a place.
module pipe_return_buffer #(
  parameter int LATENCY    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic                          issueReqIn,
  output logic                          issueGntOut,
  input  logic                          pipeValidIn,
  input  logic [DATA_WIDTH-1:0]         pipeDataIn,
  output logic                          validOut,
  output logic [DATA_WIDTH-1:0]         dataOut,
  input  logic                          readyIn,
  output logic [$clog2(DEPTH+1)-1:0]    countOut,
  output logic [$clog2(DEPTH+1)-1:0]    creditsOut,
  output logic                          errOut
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  // Elaboration-time sizing sanity; throughput below LATENCY+1 entries is legal.
  if (DEPTH < 2 || LATENCY < 1) begin : gSizeCheck
    $error("pipe_return_buffer: DEPTH must be >= 2 and LATENCY >= 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [CW-1:0]         countQ;
  logic [CW-1:0]         inFlightQ;
  logic                  errQ;

  logic                  pop;
  logic                  pipeLive;
  logic                  full;
  logic                  write;
  logic                  drop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == LAST_P) ? '0 : ptr + PW'(1);
  endfunction

  // Credits come from registered state only: a pop frees a credit next cycle.
  assign creditsOut  = DEPTH_C - countQ - inFlightQ;
  assign issueGntOut = issueReqIn && (creditsOut != '0);

  assign validOut = (countQ != '0);
  assign dataOut  = mem[rdPtr];
  assign countOut = countQ;
  assign errOut   = errQ;

  assign pop      = validOut && readyIn;
  assign pipeLive = pipeValidIn && (inFlightQ != '0);
  assign full     = (countQ == DEPTH_C);
  assign write    = pipeLive && (!full || pop);
  assign drop     = pipeValidIn && !write;

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      countQ    <= '0;
      inFlightQ <= '0;
      errQ      <= 1'b0;
    end else begin
      if (write) wrPtr <= nextPtr(wrPtr);
      if (pop)   rdPtr <= nextPtr(rdPtr);

      case ({write, pop})
        2'b10:   countQ <= countQ + CW'(1);
        2'b01:   countQ <= countQ - CW'(1);
        default: countQ <= countQ;
      endcase

      // A live return retires its reservation even if it could not be stored.
      case ({issueGntOut, pipeLive})
        2'b10:   inFlightQ <= inFlightQ + CW'(1);
        2'b01:   inFlightQ <= inFlightQ - CW'(1);
        default: inFlightQ <= inFlightQ;
      endcase

      if (drop) errQ <= 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn && write) mem[wrPtr] <= pipeDataIn;
  end

endmodule

// File: doc/pipe_return_buffer.md
PIPE_RETURN_BUFFER -- requirements
Module: pipe_return_buffer

Interface
REQ-001 Parameter LATENCY, default 8: fixed latency of the stall-free pipeline feeding pipeDataIn; used only for sizing checks.
REQ-002 Parameter DATA_WIDTH, default 32: result word width.
REQ-003 Parameter DEPTH, default 16: buffer entries; SHALL be at least 2; full throughput requires DEPTH >= LATENCY+1.
REQ-004 The block SHALL use one clock, clkIn. Reset rstIn SHALL be synchronous and active-high.
REQ-005 clkIn  input  1  clock; all state updates on rising edge.
REQ-006 rstIn  input  1  synchronous active-high reset.
REQ-007 issueReqIn  input  1  upstream requests to launch one operation into the pipeline.
REQ-008 issueGntOut  output  1  launch permitted this cycle; combinational.
REQ-009 pipeValidIn  input  1  pipeline result present this cycle.
REQ-010 pipeDataIn  input  DATA_WIDTH  pipeline result word.
REQ-011 validOut  output  1  buffer head valid.
REQ-012 dataOut  output  DATA_WIDTH  buffer head word.
REQ-013 readyIn  input  1  consumer accepts head.
REQ-014 countOut  output  clog2(DEPTH+1)  stored entries.
REQ-015 creditsOut  output  clog2(DEPTH+1)  free slots not reserved by in-flight operations.
REQ-016 errOut  output  1  sticky protocol error flag.

Function
REQ-017 Internal inFlight counter, width clog2(DEPTH+1): +1 on grant, -1 on accepted pipeValidIn; both in the same cycle leave it unchanged.
REQ-018 creditsOut SHALL equal DEPTH - countOut - inFlight, from registered state only.
REQ-019 issueGntOut SHALL equal issueReqIn AND (creditsOut != 0); no bypass, so a pop frees a credit only from the following cycle.
REQ-020 Write: pipeValidIn with inFlight != 0 and countOut != DEPTH SHALL store pipeDataIn at write pointer, advance pointer.
REQ-021 Read: validOut AND readyIn SHALL advance read pointer; a pop frees its slot from the next cycle.
REQ-022 validOut SHALL equal (countOut != 0); dataOut SHALL be the word at the read pointer (combinational read), stable while validOut=1 and readyIn=0.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, power of two or not.
REQ-024 Simultaneous write and read SHALL keep countOut unchanged, including at countOut=1; ordering SHALL be strictly FIFO.
REQ-025 pipeValidIn with inFlight=0 SHALL drop the word, leave count and pointers unchanged, and set errOut.
REQ-026 pipeValidIn with countOut=DEPTH and no read that cycle SHALL drop the word and set errOut.
REQ-027 errOut SHALL remain 1 until rstIn.
REQ-028 Data path SHALL not alter words; no arithmetic on payload.

Reset
REQ-029 On rstIn=1 at a clock edge: pointers, countOut, inFlight, errOut SHALL become 0 and creditsOut SHALL become DEPTH, overriding any same-cycle grant, write or read.
REQ-030 After reset validOut=0 and issueGntOut=issueReqIn; memory contents need not be cleared.
REQ-031 Reset mid-operation SHALL discard stored and in-flight entries; a later pipeValidIn for a discarded operation SHALL set errOut per REQ-025.

Verification (LATENCY=8, DEPTH=4, DATA_WIDTH=32)
REQ-032 Reset, idle -> creditsOut=4, countOut=0, validOut=0, errOut=0, issueGntOut=0.
REQ-033 issueReqIn=1 five consecutive cycles, readyIn=0 -> grants on first four only; creditsOut 4,3,2,1,0.
REQ-034 Return 0x11,0x22,0x33,0x44 eight cycles after their grants, readyIn=0, then readyIn=1 -> countOut reaches 4; dataOut 0x11,0x22,0x33,0x44 on consecutive cycles; validOut=0 afterwards; creditsOut back to 4.
REQ-035 countOut=2 with pipeValidIn=1 (0xAA) and readyIn=1 same cycle -> countOut stays 2; 0xAA emerges after the two older words.
REQ-036 pipeValidIn=1 with inFlight=0 -> countOut unchanged, errOut=1 and stays 1 until rstIn.
REQ-037 rstIn=1 with countOut=3, inFlight=1 -> next cycle countOut=0, creditsOut=4, validOut=0; the late return then sets errOut=1.
